instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-high
REQ-002 The command-side ports SHALL be:
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- cls  in  3  class: 0 DP-reg, 1 DP-imm, 2 MUL, 3 LDR, 4 STR, 5 B
- cmd  in  4  DP opcode (ADD 0100, SUB 0010, AND 0000, ORR 1100, CMP 1010, MOV 1101)
- s  in  1  set-flags bit
- cond  in  4  condition field
- rn, rd, rm, rs  in  4 each  register numbers
- imm12  in  12  immediate or offset field
- off24  in  24  branch word offset
- clear  in  1  restart the program at address 0
REQ-003 The memory-side and status ports SHALL be:
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  6  word address
- mem_wdata  out  32  encoded instruction
- count  out  7  instructions written so far (0..64)
- full  out  1  memory full
- err  out  1  one-cycle pulse on a rejected request
- busy  out  1  state is not IDLE

Function
REQ-004 The FSM SHALL have states IDLE, ENCODE and WRITE.
REQ-005 in_ready SHALL be 1 only when the state is IDLE, full is 0 and clear is 0.
REQ-006 A handshake (in_valid and in_ready) SHALL register all inputs and move the FSM IDLE->ENCODE.
REQ-007 ENCODE SHALL compute the word into a register and go to WRITE when the request is legal.
REQ-008 ENCODE SHALL go to IDLE and pulse err for that cycle, with no write, when the request is illegal.
REQ-009 A request SHALL be illegal when cls>5, or when cls is 0/1 and cmd is not one of the six listed opcodes.
REQ-010 WRITE SHALL assert mem_we for exactly one cycle, with mem_addr = write pointer, then go to IDLE.
REQ-011 The write pointer and count SHALL increment on the cycle after mem_we.
REQ-012 Latency SHALL be fixed: handshake at cycle N gives mem_we at cycle N+2, and the next in_ready no earlier than N+3.
REQ-013 Word bits [31:28] SHALL equal cond for every class.
REQ-014 DP encoding SHALL be: [27:26]=00, [25]=1 for cls 1 else 0, [24:21]=cmd, [20]=s, [19:16]=rn, [15:12]=rd, [11:0]=imm12 (cls 1) or {8'h00,rm} (cls 0).
REQ-015 CMP SHALL force [20]=1 and rd field=0.
REQ-016 MOV SHALL force rn field=0.
REQ-017 MUL encoding SHALL be: [27:21]=0000000, [20]=s, [19:16]=rd, [15:12]=0000, [11:8]=rs, [7:4]=1001, [3:0]=rm.
REQ-018 LDR/STR encoding SHALL be: [27:26]=01, [25:21]=01100, [20]=1 for LDR and 0 for STR, [19:16]=rn, [15:12]=rd, [11:0]=imm12.
REQ-019 B encoding SHALL be: [27:24]=1010, [23:0]=off24.
REQ-020 After the write to address 63, count SHALL be 64 and full SHALL be 1; the pointer SHALL NOT wrap, and no further requests SHALL be accepted until clear or reset.
REQ-021 clear SHALL be honored only in IDLE, setting pointer=0, count=0 and full=0 on the next cycle.
REQ-022 clear asserted in ENCODE or WRITE SHALL be ignored; the in-flight write SHALL complete.
REQ-023 If clear and in_valid are both asserted in IDLE, clear SHALL win and no handshake SHALL occur.
REQ-024 mem_wdata and mem_addr SHALL hold their last values when mem_we=0.

Reset
REQ-025 Reset SHALL force state=IDLE, and mem_we=0, err=0, busy=0, full=0, count=0, pointer=0, mem_addr=0, mem_wdata=0.
REQ-026 Reset asserted in ENCODE or WRITE SHALL abort the request, and no mem_we SHALL occur afterwards for it.

Verification
REQ-027 The bench SHALL cover: cls0 ADD cond=E rn=2 rd=1 rm=3 at N -> mem_we at N+2, addr 0, wdata E0821003, count 1 at N+3.
REQ-028 The bench SHALL cover: cls1 SUB s=1 rn=0 rd=0 imm=1 -> E2500001; cls1 CMP rn=1 rd=7 s=0 imm=5 -> E3510005.
REQ-029 The bench SHALL cover: MUL rd=3 rm=4 rs=5 -> E0030594; LDR rn=0 rd=2 imm=4 -> E5902004; B off24=2 -> EA000002.
REQ-030 The bench SHALL cover: cls0 cmd=0111 -> err pulse at N+1, no mem_we, count unchanged; cls=6 -> same.
REQ-031 The bench SHALL cover: 64 legal writes -> full=1, count=64, in_ready=0; clear in IDLE -> full=0, count=0, next write to address 0.
REQ-032 The bench SHALL cover: reset asserted in ENCODE -> no mem_we, state IDLE, and all outputs at reset values next cycle.

Source files
------------

// File: rtl/instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : instr_encoder                                                |
// | Description: Accepts one instruction request per handshake, encodes it   |
// |              into a 32-bit ARM-style word and writes it to a 64-entry    |
// |              instruction memory at a write pointer that advances after  |
// |              every write. Illegal requests raise a one-cycle err pulse. |
// | Ports      : clk, reset            - clock, synchronous active-high rst  |
// |              in_valid/in_ready     - request handshake                   |
// |              cls,cmd,s,cond,rn,rd,rm,rs,imm12,off24 - request fields     |
// |              clear                 - restart program at address 0       |
// |              mem_we/mem_addr/mem_wdata - instruction-memory write port   |
// |              count/full/err/busy   - status                              |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  cls,
    input  logic [3:0]  cmd,
    input  logic        s,
    input  logic [3:0]  cond,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [3:0]  rm,
    input  logic [3:0]  rs,
    input  logic [11:0] imm12,
    input  logic [23:0] off24,
    input  logic        clear,
    output logic        mem_we,
    output logic [5:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic [6:0]  count,
    output logic        full,
    output logic        err,
    output logic        busy
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ENCODE = 2'd1;
    localparam logic [1:0] c_ST_WRITE  = 2'd2;

    localparam logic [2:0] c_CLS_DPR = 3'd0;
    localparam logic [2:0] c_CLS_DPI = 3'd1;
    localparam logic [2:0] c_CLS_MUL = 3'd2;
    localparam logic [2:0] c_CLS_LDR = 3'd3;
    localparam logic [2:0] c_CLS_STR = 3'd4;
    localparam logic [2:0] c_CLS_B   = 3'd5;

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0010;
    localparam logic [3:0] c_OP_ADD = 4'b0100;
    localparam logic [3:0] c_OP_CMP = 4'b1010;
    localparam logic [3:0] c_OP_ORR = 4'b1100;
    localparam logic [3:0] c_OP_MOV = 4'b1101;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    // Captured request fields
    logic [2:0]  r_cls;
    logic [3:0]  r_cmd;
    logic        r_s;
    logic [3:0]  r_cond;
    logic [3:0]  r_rn;
    logic [3:0]  r_rd;
    logic [3:0]  r_rm;
    logic [3:0]  r_rs;
    logic [11:0] r_imm12;
    logic [23:0] r_off24;

    logic [5:0]  r_ptr;
    logic [6:0]  r_count;
    logic        r_full;
    logic [5:0]  r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_handshake;
    logic        w_cmd_ok;
    logic        w_is_cmp;
    logic        w_is_mov;
    logic        w_legal;
    logic [31:0] w_word;

    assign w_handshake = in_valid && in_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_handshake) w_state_nxt = c_ST_ENCODE;
            c_ST_ENCODE: w_state_nxt = w_legal ? c_ST_WRITE : c_ST_IDLE;
            c_ST_WRITE:  w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = (r_state == c_ST_IDLE) && !r_full && !clear;
        mem_we   = (r_state == c_ST_WRITE);
        err      = (r_state == c_ST_ENCODE) && !w_legal;
        busy     = (r_state != c_ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    always_comb begin
        w_cmd_ok = (r_cmd == c_OP_AND) || (r_cmd == c_OP_SUB) ||
                   (r_cmd == c_OP_ADD) || (r_cmd == c_OP_CMP) ||
                   (r_cmd == c_OP_ORR) || (r_cmd == c_OP_MOV);
        w_is_cmp = (r_cmd == c_OP_CMP);
        w_is_mov = (r_cmd == c_OP_MOV);
    end

    always_comb begin
        w_legal = 1'b0;
        w_word  = 32'h0000_0000;
        case (r_cls)
            c_CLS_DPR, c_CLS_DPI: begin
                w_legal = w_cmd_ok;
                // CMP always sets flags and has no destination; MOV has no Rn.
                w_word  = {r_cond, 2'b00, (r_cls == c_CLS_DPI), r_cmd,
                           (r_s | w_is_cmp),
                           (w_is_mov ? 4'h0 : r_rn),
                           (w_is_cmp ? 4'h0 : r_rd),
                           ((r_cls == c_CLS_DPI) ? r_imm12 : {8'h00, r_rm})};
            end
            c_CLS_MUL: begin
                w_legal = 1'b1;
                w_word  = {r_cond, 7'b0000000, r_s, r_rd, 4'b0000, r_rs,
                           4'b1001, r_rm};
            end
            c_CLS_LDR, c_CLS_STR: begin
                w_legal = 1'b1;
                w_word  = {r_cond, 2'b01, 5'b01100, (r_cls == c_CLS_LDR),
                           r_rn, r_rd, r_imm12};
            end
            c_CLS_B: begin
                w_legal = 1'b1;
                w_word  = {r_cond, 4'b1010, r_off24};
            end
            default: begin
                w_legal = 1'b0;
                w_word  = 32'h0000_0000;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cls   <= 3'd0;
            r_cmd   <= 4'd0;
            r_s     <= 1'b0;
            r_cond  <= 4'd0;
            r_rn    <= 4'd0;
            r_rd    <= 4'd0;
            r_rm    <= 4'd0;
            r_rs    <= 4'd0;
            r_imm12 <= 12'd0;
            r_off24 <= 24'd0;
        end else if (w_handshake) begin
            r_cls   <= cls;
            r_cmd   <= cmd;
            r_s     <= s;
            r_cond  <= cond;
            r_rn    <= rn;
            r_rd    <= rd;
            r_rm    <= rm;
            r_rs    <= rs;
            r_imm12 <= imm12;
            r_off24 <= off24;
        end
    end

    // ------------------------------------------------------------------
    // Memory port registers: loaded only when a legal word leaves ENCODE,
    // so address and data hold between writes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr  <= 6'd0;
            r_mem_wdata <= 32'h0000_0000;
        end else if ((r_state == c_ST_ENCODE) && w_legal) begin
            r_mem_addr  <= r_ptr;
            r_mem_wdata <= w_word;
        end
    end

    // ------------------------------------------------------------------
    // Write pointer, count and full flag. Clear is only looked at in IDLE,
    // so a write already in flight always completes and is counted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= 6'd0;
            r_count <= 7'd0;
            r_full  <= 1'b0;
        end else if ((r_state == c_ST_IDLE) && clear) begin
            r_ptr   <= 6'd0;
            r_count <= 7'd0;
            r_full  <= 1'b0;
        end else if (r_state == c_ST_WRITE) begin
            // Pointer saturates at 63 rather than wrapping; full then blocks input.
            if (r_ptr != 6'd63) begin
                r_ptr <= r_ptr + 6'd1;
            end
            r_count <= r_count + 7'd1;
            r_full  <= (r_count == 7'd63);
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign count     = r_count;
    assign full      = r_full;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_instr_encoder                                             |
// | Description: Directed self-checking bench for instr_encoder.             |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_instr_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  cls;
    logic [3:0]  cmd;
    logic        s;
    logic [3:0]  cond;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  rs;
    logic [11:0] imm12;
    logic [23:0] off24;
    logic        clear;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [6:0]  count;
    logic        full;
    logic        err;
    logic        busy;

    int r_n_checks;
    int r_n_fail;
    int r_exp_count;

    instr_encoder u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cls       (cls),
        .cmd       (cmd),
        .s         (s),
        .cond      (cond),
        .rn        (rn),
        .rd        (rd),
        .rm        (rm),
        .rs        (rs),
        .imm12     (imm12),
        .off24     (off24),
        .clear     (clear),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .full      (full),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_n_checks++;
        if (obs !== exp) begin
            r_n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One request: handshake in cycle N, then checks at N+1, N+2, N+3.
    // clr_fl holds clear high while the request is in flight.
    task automatic send(input logic [2:0] t_cls, input logic [3:0] t_cmd,
                        input logic t_s, input logic [3:0] t_cond,
                        input logic [3:0] t_rn, input logic [3:0] t_rd,
                        input logic [3:0] t_rm, input logic [3:0] t_rs,
                        input logic [11:0] t_imm, input logic [23:0] t_off,
                        input logic legal, input logic [31:0] exp_word,
                        input logic clr_fl);
        logic [5:0]  exp_addr;
        logic [5:0]  prev_addr;
        logic [31:0] prev_wdata;
        exp_addr = r_exp_count[5:0];
        @(posedge clk); #1;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        cls = t_cls; cmd = t_cmd; s = t_s; cond = t_cond;
        rn = t_rn; rd = t_rd; rm = t_rm; rs = t_rs;
        imm12 = t_imm; off24 = t_off;
        in_valid = 1'b1;
        @(negedge clk);
        check("in_ready", in_ready, 1);
        @(posedge clk); #1;                   // cycle N+1
        in_valid = 1'b0;
        clear = clr_fl;
        @(negedge clk);
        check("err_n1", err, !legal);
        check("we_n1", mem_we, 0);
        check("busy_n1", busy, 1);
        check("in_ready_busy", in_ready, 0);
        @(posedge clk); #1;                   // cycle N+2
        @(negedge clk);
        check("err_n2", err, 0);
        if (legal) begin
            check("we_n2", mem_we, 1);
            check("addr", mem_addr, exp_addr);
            check("wdata", mem_wdata, exp_word);
            r_exp_count++;
        end else begin
            check("we_n2_none", mem_we, 0);
            check("addr_hold", mem_addr, prev_addr);
            check("wdata_hold", mem_wdata, prev_wdata);
        end
        @(posedge clk); #1;                   // cycle N+3
        clear = 1'b0;
        @(negedge clk);
        check("we_n3", mem_we, 0);
        check("count", count, r_exp_count);
        check("busy_n3", busy, 0);
        if (legal) begin
            check("addr_keep", mem_addr, exp_addr);
            check("wdata_keep", mem_wdata, exp_word);
        end
    endtask

    initial begin
        r_n_checks  = 0;
        r_n_fail    = 0;
        r_exp_count = 0;
        reset = 1'b1; in_valid = 1'b0; clear = 1'b0;
        cls = 3'd0; cmd = 4'd0; s = 1'b0; cond = 4'd0;
        rn = 4'd0; rd = 4'd0; rm = 4'd0; rs = 4'd0; imm12 = 12'd0; off24 = 24'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we", mem_we, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Legal encodings
        send(3'd0, 4'b0100, 1'b0, 4'hE, 4'd2, 4'd1, 4'd3, 4'd0, 12'h000, 24'h0, 1'b1, 32'hE0821003, 1'b0);
        send(3'd1, 4'b0010, 1'b1, 4'hE, 4'd0, 4'd0, 4'd0, 4'd0, 12'h001, 24'h0, 1'b1, 32'hE2500001, 1'b0);
        send(3'd1, 4'b1010, 1'b0, 4'hE, 4'd1, 4'd7, 4'd0, 4'd0, 12'h005, 24'h0, 1'b1, 32'hE3510005, 1'b0);
        send(3'd2, 4'b0000, 1'b0, 4'hE, 4'd0, 4'd3, 4'd4, 4'd5, 12'h000, 24'h0, 1'b1, 32'hE0030594, 1'b0);
        send(3'd3, 4'b0000, 1'b0, 4'hE, 4'd0, 4'd2, 4'd0, 4'd0, 12'h004, 24'h0, 1'b1, 32'hE5902004, 1'b0);
        send(3'd5, 4'b0000, 1'b0, 4'hE, 4'd0, 4'd0, 4'd0, 4'd0, 12'h000, 24'h2, 1'b1, 32'hEA000002, 1'b0);
        send(3'd0, 4'b1101, 1'b0, 4'h0, 4'd5, 4'd6, 4'd7, 4'd0, 12'h000, 24'h0, 1'b1, 32'h01A06007, 1'b0);
        send(3'd4, 4'b0000, 1'b0, 4'h1, 4'd3, 4'd4, 4'd0, 4'd0, 12'hABC, 24'h0, 1'b1, 32'h15834ABC, 1'b0);

        // Illegal requests
        send(3'd0, 4'b0111, 1'b0, 4'hE, 4'd1, 4'd1, 4'd1, 4'd0, 12'h000, 24'h0, 1'b0, 32'h0, 1'b0);
        send(3'd6, 4'b0100, 1'b0, 4'hE, 4'd1, 4'd1, 4'd1, 4'd0, 12'h000, 24'h0, 1'b0, 32'h0, 1'b0);

        // Fill memory to 64 entries
        while (r_exp_count < 64) begin
            send(3'd5, 4'b0000, 1'b0, 4'hE, 4'd0, 4'd0, 4'd0, 4'd0, 12'h000,
                 24'(r_exp_count), 1'b1, 32'hEA000000 | 32'(r_exp_count), 1'b0);
        end
        check("full_set", full, 1);
        check("count_64", count, 64);
        @(posedge clk); #1;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_ready", in_ready, 0);
            check("full_busy", busy, 0);
            check("full_we", mem_we, 0);
        end

        // clear beats in_valid in IDLE
        @(posedge clk); #1;
        clear = 1'b1;
        @(negedge clk);
        check("clr_ready", in_ready, 0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("clr_busy", busy, 0);
        check("clr_full", full, 0);
        check("clr_count", count, 0);
        r_exp_count = 0;
        send(3'd0, 4'b0100, 1'b0, 4'hE, 4'd2, 4'd1, 4'd3, 4'd0, 12'h000, 24'h0, 1'b1, 32'hE0821003, 1'b0);

        // clear during ENCODE/WRITE is ignored
        send(3'd2, 4'b0000, 1'b0, 4'hE, 4'd0, 4'd3, 4'd4, 4'd5, 12'h000, 24'h0, 1'b1, 32'hE0030594, 1'b1);

        // reset during ENCODE aborts the request
        @(posedge clk); #1;
        cls = 3'd5; cond = 4'hE; off24 = 24'h7; in_valid = 1'b1;
        @(posedge clk); #1;                   // ENCODE
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_we", mem_we, 0);
        check("abort_busy", busy, 0);
        check("abort_err", err, 0);
        check("abort_full", full, 0);
        check("abort_count", count, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_wdata", mem_wdata, 0);
        check("abort_ready", in_ready, 1);
        @(negedge clk);
        check("abort_we_late", mem_we, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", r_n_checks, r_n_fail);
        $finish;
    end

endmodule
`default_nettype wire
